// File: rtl/seqgen_pkg.sv
// Shared definitions for the sequence generator / checker pair: state
// encoding, counter-width helper and the default idle line level.
package seqgen_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic DEF_IDLE_LEVEL = 1'b0;

  // Width of a counter that must hold WIDTH-1; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_serializer_if.sv
// Word-load handshake between a pattern source and seq_serializer.
interface seq_serializer_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;

  modport master (output load_data, load_valid, input load_ready);
  modport slave  (input load_data, load_valid, output load_ready);

endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial generator: shifts accepted words out MSB-first, one bit
// per bit_en strobe. Define SEQ_SERIALIZER_LOOP_EN to add word looping.
module seq_serializer
  import seqgen_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL,
  localparam int  CNT_W      = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  seq_serializer_if.slave  ld,
  input  logic             bit_en,
`ifdef SEQ_SERIALIZER_LOOP_EN
  input  logic             loop_en,
`endif
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt
);

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [CNT_W-1:0] cnt_d;
  logic             ser_out_d, ser_valid_d, done_d;
  logic             last_bit, xfer;
`ifdef SEQ_SERIALIZER_LOOP_EN
  logic [WIDTH-1:0] copy_q, copy_d;
`endif

  // The final bit period ends on this edge; a new word may load gaplessly.
  assign last_bit      = (state == ST_SHIFT) && (bit_cnt == '0) && bit_en;
  assign ld.load_ready = (state == ST_IDLE) || last_bit;
  assign xfer          = ld.load_valid && ld.load_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path infers a latch.
    state_d     = state;
    shreg_d     = shreg;
    cnt_d       = bit_cnt;
    ser_out_d   = ser_out;
    ser_valid_d = ser_valid;
    done_d      = last_bit;
`ifdef SEQ_SERIALIZER_LOOP_EN
    copy_d      = copy_q;
`endif

    if (xfer) begin
      state_d     = ST_SHIFT;
      ser_out_d   = ld.load_data[WIDTH-1];
      shreg_d     = ld.load_data << 1;
      cnt_d       = CNT_W'(WIDTH - 1);
      ser_valid_d = 1'b1;
`ifdef SEQ_SERIALIZER_LOOP_EN
      copy_d      = ld.load_data;
`endif
    end else if (last_bit) begin
`ifdef SEQ_SERIALIZER_LOOP_EN
      if (loop_en) begin
        // Replay the last accepted word exactly as if it were freshly loaded.
        ser_out_d   = copy_q[WIDTH-1];
        shreg_d     = copy_q << 1;
        cnt_d       = CNT_W'(WIDTH - 1);
        ser_valid_d = 1'b1;
      end else
`endif
      begin
        state_d     = ST_IDLE;
        ser_out_d   = IDLE_LEVEL;
        ser_valid_d = 1'b0;
      end
    end else if ((state == ST_SHIFT) && bit_en) begin
      ser_out_d = shreg[WIDTH-1];
      shreg_d   = shreg << 1;
      cnt_d     = bit_cnt - 1'b1;
    end
  end

  // NOTE: registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      ser_out   <= IDLE_LEVEL;
      ser_valid <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_SERIALIZER_LOOP_EN
      copy_q    <= '0;
`endif
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      bit_cnt   <= cnt_d;
      ser_out   <= ser_out_d;
      ser_valid <= ser_valid_d;
      done      <= done_d;
`ifdef SEQ_SERIALIZER_LOOP_EN
      copy_q    <= copy_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer: directed patterns plus randomized
// traffic compared every cycle against a queue-based bit-stream model.
module tb_seq_serializer;
  import seqgen_pkg::*;

  localparam int W  = 8;
  localparam int CW = cnt_w(W);

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_en;
`ifdef SEQ_SERIALIZER_LOOP_EN
  logic          loop_en;
`endif
  logic          ser_out, ser_valid, done;
  logic [CW-1:0] bit_cnt;

  seq_serializer_if #(.WIDTH(W)) ld ();

  seq_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld        (ld),
    .bit_en    (bit_en),
`ifdef SEQ_SERIALIZER_LOOP_EN
    .loop_en   (loop_en),
`endif
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .done      (done),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the bits still owed for the current word, front = on the line now.
  bit             m_q[$];
  logic [W-1:0]   m_last = '0;
  bit             m_done = 1'b0;

  function automatic bit m_ready();
    return (m_q.size() == 0) || (m_q.size() == 1 && bit_en);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_done = 1'b0;
    end else begin
      automatic bit rdy = m_ready();
      m_done = (m_q.size() == 1) && bit_en;
      if (ld.load_valid && rdy) begin
        m_q.delete();
        for (int i = W - 1; i >= 0; i--) m_q.push_back(ld.load_data[i]);
        m_last = ld.load_data;
      end else if (m_q.size() > 0 && bit_en) begin
        void'(m_q.pop_front());
`ifdef SEQ_SERIALIZER_LOOP_EN
        if (m_q.size() == 0 && loop_en)
          for (int i = W - 1; i >= 0; i--) m_q.push_back(m_last[i]);
`endif
      end
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      automatic int n = m_q.size();
      check("cyc_ser_valid",  ser_valid,      (n > 0));
      check("cyc_ser_out",    ser_out,        (n > 0) ? m_q[0] : 1'b0);
      check("cyc_bit_cnt",    bit_cnt,        (n > 0) ? n - 1 : 0);
      check("cyc_done",       done,           m_done);
      check("cyc_load_ready", ld.load_ready,  m_ready());
    end
  end

  // Recorder of the emitted stream for the directed literal checks.
  bit          rec_on = 1'b0;
  bit          rec_bits[$];
  int          rec_dpos[$];
  int          rec_done, rec_cyc, rec_first, rec_last;
  int          rec_cnt_first, rec_cnt_last;

  always @(negedge clk) begin
    if (rec_on) begin
      if (done) begin
        rec_done++;
        rec_dpos.push_back(rec_bits.size());
      end
      if (ser_valid) begin
        if (rec_bits.size() == 0) begin
          rec_first     = rec_cyc;
          rec_cnt_first = int'(bit_cnt);
        end
        rec_last     = rec_cyc;
        rec_cnt_last = int'(bit_cnt);
        rec_bits.push_back(ser_out);
      end
      rec_cyc++;
    end
  end

  task automatic rec_clear();
    rec_bits.delete();
    rec_dpos.delete();
    rec_done = 0; rec_cyc = 0; rec_first = 0; rec_last = 0;
    rec_cnt_first = -1; rec_cnt_last = -1;
    rec_on = 1'b1;
  endtask

  function automatic logic [31:0] rec_pack();
    logic [31:0] v = '0;
    foreach (rec_bits[i]) v = {v[30:0], rec_bits[i]};
    return v;
  endfunction

  function automatic int dpos(input int i);
    return (rec_dpos.size() > i) ? rec_dpos[i] : -1;
  endfunction

  // Stimulus pacing: inputs change only at posedge+1.
  int en_mode   = 0;    // 0: always 1, 1: one clock in 4, 2: random
  int div_phase = 0;
  bit last_xfer;

  task automatic apply_en();
    case (en_mode)
      0:       bit_en = 1'b1;
      1: begin bit_en = (div_phase == 0); div_phase = (div_phase + 1) % 4; end
      default: bit_en = ($urandom_range(3) != 0);
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    last_xfer = ld.load_valid && ld.load_ready;
    @(posedge clk);
    #1;
    apply_en();
  endtask

  task automatic send_word(input logic [W-1:0] d, input bit hold, output int waits);
    ld.load_data  = d;
    ld.load_valid = 1'b1;
    waits = 0;
    step();
    while (!last_xfer && waits < 100) begin
      waits++;
      step();
    end
    check("send_accepted", last_xfer, 1'b1);
    if (!hold) ld.load_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int w;
    rst = 1'b0;
    bit_en = 1'b1;
`ifdef SEQ_SERIALIZER_LOOP_EN
    loop_en = 1'b0;
`endif
    ld.load_valid = 1'b0;
    ld.load_data  = '0;

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    check("rst_ser_out",    ser_out,       1'b0);
    check("rst_ser_valid",  ser_valid,     1'b0);
    check("rst_done",       done,          1'b0);
    check("rst_bit_cnt",    bit_cnt,       0);
    check("rst_load_ready", ld.load_ready, 1'b1);
    chk_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: single word from reset
    rec_clear();
    send_word(8'b0010_1011, 1'b0, w);
    repeat (10) step();
    check("t1_nbits",  rec_bits.size(), 8);
    check("t1_bits",   rec_pack(),      32'h2B);
    check("t1_done",   rec_done,        1);
    check("t1_dpos",   dpos(0),         8);
    check("t1_idle",   ser_out,         1'b0);
    check("t1_ready",  ld.load_ready,   1'b1);

    // 2: gapless back-to-back
    rec_clear();
    send_word(8'hA5, 1'b1, w);
    send_word(8'h3C, 1'b0, w);
    repeat (12) step();
    check("t2_nbits",   rec_bits.size(),         16);
    check("t2_bits",    rec_pack(),              32'hA53C);
    check("t2_contig",  rec_last - rec_first + 1, 16);
    check("t2_done",    rec_done,                2);
    check("t2_dpos0",   dpos(0),                 8);
    check("t2_dpos1",   dpos(1),                 16);

    // 3: slow strobe, one bit_en in four
    en_mode = 1; div_phase = 0; apply_en();
    rec_clear();
    send_word(8'h81, 1'b0, w);
    repeat (40) step();
    check("t3_cycles",    rec_bits.size(), 32);
    check("t3_bits",      rec_pack(),      32'hF000000F);
    check("t3_cnt_first", rec_cnt_first,   7);
    check("t3_cnt_last",  rec_cnt_last,    0);
    check("t3_done",      rec_done,        1);
    en_mode = 0; apply_en();

    // 4: stall while a word is in progress
    rec_clear();
    send_word(8'h12, 1'b0, w);
    send_word(8'hFF, 1'b0, w);
    check("t4_stall_cycles", w, 7);
    ld.load_data = 8'h00;
    repeat (12) step();
    check("t4_nbits", rec_bits.size(), 16);
    check("t4_bits",  rec_pack(),      32'h12FF);

    // 5: reset mid-word acts without a clock
    rec_clear();
    send_word(8'hF0, 1'b0, w);
    repeat (2) step();
    #1;
    rst = 1'b0;
    #1;
    check("t5_ser_out",   ser_out,   1'b0);
    check("t5_ser_valid", ser_valid, 1'b0);
    check("t5_done",      done,      1'b0);
    check("t5_bit_cnt",   bit_cnt,   0);
    repeat (2) step();
    rst = 1'b1;
    rec_clear();
    repeat (12) step();
    check("t5_no_bits", rec_bits.size(), 0);
    check("t5_no_done", rec_done,        0);

`ifdef SEQ_SERIALIZER_LOOP_EN
    // 6: loop the last word three times
    loop_en = 1'b1;
    rec_clear();
    send_word(8'h96, 1'b0, w);
    repeat (19) step();
    loop_en = 1'b0;
    repeat (12) step();
    check("t6_nbits", rec_bits.size(), 24);
    check("t6_bits",  rec_pack(),      32'h969696);
    check("t6_done",  rec_done,        3);
    check("t6_idle",  ser_valid,       1'b0);
`endif

    // Randomized traffic against the model, with one asynchronous reset.
    rec_on  = 1'b0;
    en_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      step();
      if (last_xfer || !ld.load_valid) begin
        ld.load_valid = ($urandom_range(3) != 0);
        ld.load_data  = W'($urandom);
      end
`ifdef SEQ_SERIALIZER_LOOP_EN
      if ($urandom_range(15) == 0) loop_en = ~loop_en;
`endif
      if (i == 700) begin
        #2;
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
      end
    end

    ld.load_valid = 1'b0;
    repeat (3) step();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
Parallel-to-serial bit-stream generator that sits directly upstream of the sequence checker FSM and drives its serial `in` input.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Emits the word MSB-first, one bit per `bit_en` strobe, so test patterns reach the checker as a clean one-bit stream.
- Supports gapless back-to-back words, so patterns can straddle word boundaries.

Parameters:
WIDTH, 8, bits per word; legal range is 2 to 32.
IDLE_LEVEL, 1'b0, level driven on ser_out when no word is being shifted.

Ports:
clk  in  1  system clock; all state changes on its rising edge.
rst  in  1  asynchronous, active-low reset.
load_data  in  WIDTH  word to serialise; bit WIDTH-1 goes out first.
load_valid  in  1  load_data is valid.
load_ready  out  1  block can accept a word on this edge.
bit_en  in  1  bit-advance strobe; tie to 1 for one bit per clock.
ser_out  out  1  serial bit; connects to the checker's `in`.
ser_valid  out  1  ser_out carries a word bit.
done  out  1  one-cycle pulse when the last bit's period ends.
bit_cnt  out  CNT_W  bits remaining after the current one (debug, like statout); CNT_W = clog2(WIDTH).

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - state=IDLE, shift register=0, bit_cnt=0.
  - ser_out=IDLE_LEVEL, ser_valid=0, done=0.
  - Reset mid-word discards the word; there is no partial completion and no done pulse.
- States: IDLE, SHIFT. State is registered; all outputs are registered except load_ready.
- load_ready = (state==IDLE) | (state==SHIFT & bit_cnt==0 & bit_en). It is combinational.
- Transfer: happens on a rising edge with load_valid & load_ready. At that same edge:
  - ser_out <= load_data[WIDTH-1]
  - shreg <= load_data<<1
  - bit_cnt <= WIDTH-1
  - ser_valid <= 1, state <= SHIFT
- Latency: the first bit is visible in the cycle after the transfer edge.
- Bit timing: each bit is held until the next edge with bit_en=1. bit_en is ignored in IDLE.
- SHIFT, bit_en=1, bit_cnt>0: ser_out <= shreg[WIDTH-1], shreg <<= 1, bit_cnt--.
- SHIFT, bit_en=1, bit_cnt==0 (last bit period ends):
  - With load_valid=1: the new word loads as a transfer (gapless). done=1 that cycle, and ser_valid stays 1.
  - With load_valid=0: state <= IDLE, ser_out <= IDLE_LEVEL, ser_valid <= 0, done <= 1 for exactly one cycle.
- SHIFT, bit_en=0: everything holds.
- Word length: exactly WIDTH bits are emitted per accepted word, never more or fewer.
- Handshake rules:
  - load_data is sampled only on the transfer edge; later changes are ignored.
  - load_valid asserted while load_ready=0 stalls with no effect.
- done is cleared on every other edge.

Optional Feature:
SEQ_SERIALIZER_LOOP_EN
- With the macro defined:
  - Adds input port `loop_en` (1 bit) and an internal WIDTH-bit copy of the last accepted word.
  - At the last-bit edge with load_valid=0 and loop_en=1, the copy reloads as if freshly transferred.
  - done still pulses, ser_valid stays 1, state stays SHIFT.
  - A new load_valid at that edge takes priority over looping.
  - Dropping loop_en mid-word finishes the current word, then goes to IDLE.
- Without the macro: no loop_en port, no copy register, one-shot behaviour only.

Decomposition:
- Shared package seqgen_pkg holds:
  - state encoding constants: ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - the CNT_W width function (clog2);
  - the default IDLE_LEVEL.
- The checker may reuse the same package for its own state constants.
- No sub-module is needed. bit_en comes from the existing clock-divider tick in the design.

Test Plan:
1. Pattern from reset: WIDTH=8, bit_en=1, rst low 100 ns then high, load 8'b0010_1011. Expect ser_out 0,0,1,0,1,0,1,1 on 8 consecutive cycles, ser_valid=1 for those 8 cycles, done pulses once, then ser_out=0 and load_ready=1.
2. Gapless back-to-back: load 8'hA5 then hold load_valid with 8'h3C. Expect 16 contiguous bits 1010_0101_0011_1100, ser_valid never dropping, and done pulsing after bit 8 and after bit 16.
3. Slow strobe: bit_en asserted 1 clock in 4, load 8'h81. Expect each bit held exactly 4 cycles, bit_cnt counting 7→0, and 32 cycles total from transfer to IDLE.
4. Stall: load_valid=1 with 8'hFF during a word in progress. Expect load_ready=0 until the last-bit strobe, and load_data changes before that edge ignored.
5. Reset mid-word: drive rst=0 after 3 bits of 8'hF0. Expect ser_out=0, ser_valid=0, and done=0 immediately without waiting for clk, and no further bits after release.
6. (SEQ_SERIALIZER_LOOP_EN) load 8'h96 with loop_en=1 for 3 words' worth of bits, then loop_en=0. Expect 10010110 repeated exactly 3 times, 3 done pulses, then IDLE.
